// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC front end and its phase generator.
package cordic_pkg;

   localparam int FRAC_BITS = 14;
   localparam int PI        = 51472;   // round(pi * 2^14)
   localparam int TWO_PI    = 102944;  // twice PI, so the wrap interval is exact

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } phase_gen_state_t;

endpackage

// File: rtl/phase_wrap.sv
// Combinational wrapped phase adder: next = acc + inc folded back into [-PI, PI).
// One correction is enough because |inc| < TWO_PI and acc is already in range.
module phase_wrap
   import cordic_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic signed [DATA_WIDTH-1:0] acc_i,
   input  logic signed [DATA_WIDTH-1:0] inc_i,
   output logic signed [DATA_WIDTH-1:0] next_o
);

   localparam logic signed [DATA_WIDTH:0] PI_W     = (DATA_WIDTH+1)'(PI);
   localparam logic signed [DATA_WIDTH:0] NEG_PI_W = -(DATA_WIDTH+1)'(PI);
   localparam logic signed [DATA_WIDTH:0] TWO_PI_W = (DATA_WIDTH+1)'(TWO_PI);

   logic signed [DATA_WIDTH:0] acc_x;
   logic signed [DATA_WIDTH:0] inc_x;
   logic signed [DATA_WIDTH:0] sum;
   logic signed [DATA_WIDTH:0] res;

   // Sum one bit wider than the operands, then fold back into range.
   always_comb begin
      acc_x = acc_i;
      inc_x = inc_i;
      sum   = acc_x + inc_x;
      if (sum >= PI_W) begin
         res = sum - TWO_PI_W;
      end else if (sum < NEG_PI_W) begin
         res = sum + TWO_PI_W;
      end else begin
         res = sum;
      end
      next_o = res[DATA_WIDTH-1:0];
   end

endmodule

// File: rtl/phase_gen.sv
// Phase generator: emits num_samples wrapped angles into the CORDIC input FIFO,
// starting at phase_init and stepping by phase_inc, honouring the FIFO full flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; configuration not yet latched
// RUN     | presenting the accumulator; writes whenever the FIFO has room
// DONE    | one-cycle completion pulse, then back to IDLE
module phase_gen
   import cordic_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int FRAC_BITS   = cordic_pkg::FRAC_BITS,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic signed [DATA_WIDTH-1:0]  phase_init,
   input  logic signed [DATA_WIDTH-1:0]  phase_inc,
   input  logic        [COUNT_WIDTH-1:0] num_samples,
   output logic signed [DATA_WIDTH-1:0]  p_fixed,
   output logic                          in_wr_en,
   input  logic                          in_full,
   output logic                          busy,
   output logic                          done
);

   // The angle format is shared with the CORDIC core; a mismatch is a build error.
   if (FRAC_BITS != cordic_pkg::FRAC_BITS) begin : g_frac_check
      $error("phase_gen FRAC_BITS does not match cordic_pkg");
   end

   phase_gen_state_t              state_q, state_d;
   logic signed [DATA_WIDTH-1:0]  acc_q, acc_d;
   logic signed [DATA_WIDTH-1:0]  inc_q, inc_d;
   logic        [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic signed [DATA_WIDTH-1:0]  acc_next;
   logic                          wr;

   phase_wrap #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_wrap (
      .acc_i  (acc_q),
      .inc_i  (inc_q),
      .next_o (acc_next)
   );

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         inc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         inc_q   <= inc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, latch-on-start, and advance-on-write logic.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      inc_d   = inc_q;
      cnt_d   = cnt_q;
      // Reset suppresses the strobe in the cycle it is applied, so no write
      // slips into the FIFO from a run that is being aborted.
      wr      = (state_q == ST_RUN) && !in_full && !reset;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (num_samples == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
                  acc_d   = phase_init;
                  inc_d   = phase_inc;
                  cnt_d   = num_samples;
               end
            end
         end
         ST_RUN: begin
            if (wr) begin
               acc_d = acc_next;
               cnt_d = cnt_q - COUNT_WIDTH'(1);
               if (cnt_q == COUNT_WIDTH'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign p_fixed  = acc_q;
   assign in_wr_en = wr;
   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);

endmodule

// File: doc/phase_gen.md
# phase_gen

Programmable phase generator feeding the CORDIC front end. It produces a stream of signed fixed-point radian angles, starting at a programmed initial phase and advancing by a programmed increment per sample, wrapped to [-PI, PI). Its write side connects directly to the CORDIC input FIFO (`p_fixed`, `in_wr_en`, `in_full`) and obeys its backpressure. It emits exactly `num_samples` angles per start command.

## Interface
- DATA_WIDTH, 32: angle width, signed two's complement.
- FRAC_BITS, 14: fractional bits of the angle format; must match the CORDIC quantisation.
- COUNT_WIDTH, 16: width of the sample counter.
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; latches the configuration and begins a run; honoured only in IDLE.
- phase_init  in  DATA_WIDTH  first angle of the run; must lie in [-PI, PI).
- phase_inc  in  DATA_WIDTH  signed per-sample step; |phase_inc| < TWO_PI.
- num_samples  in  COUNT_WIDTH  angles to emit; 0 is legal.
- p_fixed  out  DATA_WIDTH  current angle, to the FIFO din.
- in_wr_en  out  1  FIFO write strobe.
- in_full  in  1  FIFO full flag.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run completes.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on `start` when `num_samples != 0`. On that transition latch `phase_init` into the accumulator, `phase_inc` into the increment register, and `num_samples` into the remaining counter.
- IDLE -> DONE on `start` when `num_samples == 0`. No writes occur in this case.
- RUN:
  - `in_wr_en = !in_full`, combinational.
  - On each write, the accumulator takes the wrapped sum and the counter decrements.
  - When the counter reaches 1 and a write occurs, go to DONE.
- DONE: assert `done` for one cycle, then return to IDLE unconditionally.
- `start` is ignored outside IDLE. Latched configuration is immune to input changes during a run.
- Wrap arithmetic:
  - Compute `sum = acc + inc` at DATA_WIDTH+1 bits.
  - If `sum >= PI`, the result is `sum - TWO_PI`.
  - Else if `sum < -PI`, the result is `sum + TWO_PI`.
  - Otherwise the result is `sum`.
  - The result always lies in [-PI, PI); a single correction suffices under the `phase_inc` precondition.
- `p_fixed` = accumulator register. It is not gated by `in_wr_en`; the FIFO samples it only when written.
- Precondition violations (`phase_init` out of range, |`phase_inc`| >= TWO_PI) are undefined behaviour. The bench asserts the preconditions.

## Timing
- Reset values: state IDLE, accumulator 0, counter 0, `p_fixed` 0, `in_wr_en` 0, `busy` 0, `done` 0.
- Latency: `start` accepted in cycle 0. `busy` rises and the first write (angle = `phase_init`) can occur in cycle 1.
- Throughput: one angle per cycle while `in_full` is low.
- Backpressure:
  - `in_full` high means no write, and the accumulator and counter hold.
  - Writing resumes in the same cycle `in_full` falls.
- Completion:
  - The last write occurs in cycle k. `busy` falls and `done` pulses in cycle k+1. IDLE is reached in cycle k+2, when a new `start` is accepted.
  - For `num_samples == 0`, `done` pulses in cycle 1 with `busy` held low.
- `reset` mid-run: the next cycle is the reset state. No further writes; no `done`.
- `reset` and `start` in the same cycle: reset wins.

## Structure
- Shared package `cordic_pkg`:
  - `FRAC_BITS`.
  - `PI = 51472` (round(pi·2^14)) and `TWO_PI = 102944`.
  - The FSM state enum `phase_gen_state_t`.
  - These constants are reused by the CORDIC core and the testbench models.
- Sub-module `phase_wrap`: combinational wrapped adder (acc, inc -> next acc). It is unit-testable and reusable for a future frequency-sweep generator.
- `phase_gen` holds the FSM, registers, and counter. Target size is about 150 lines.

## Test plan
- Basic wrap: init 0, inc 25736, N=5, FIFO never full -> writes 0, 25736, -51472, -25736, 0 on consecutive cycles 1–5; `done` in cycle 6.
- Negative increment: init 0, inc -25736, N=4 -> 0, -25736, -51472, 25736.
- Backpressure: inc 1000, N=4, `in_full` high in cycles 2–4 -> writes 0 (cycle 1), 1000 (cycle 5), 2000, 3000. No value is skipped or duplicated.
- Zero count: N=0 -> no `in_wr_en`, `busy` stays 0, `done` pulses in cycle 1.
- Start while busy: second `start` with different config mid-run -> ignored; original sequence completes unchanged.
- Reset mid-run: init 0, inc 100, N=10, `reset` in cycle 4 -> exactly 3 writes (0, 100, 200), no `done`, all outputs 0 the next cycle; a subsequent `start` runs normally.
